gf_arith_unit: RTL and testbench

//  Parametrised GF(2^m) arithmetic engine for the BCH decoder: multiply, square and inverse.

---
 rtl/gf_arith_if.sv | 25 ++
 rtl/gf_arith_unit.sv | 203 ++++++++++++++++++++
 tb/tb_gf_arith_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gf_arith_if.sv
// Request/response bundle of the GF(2^m) arithmetic engine.
// The master drives the request side and the slave drives the results.
interface gf_arith_if #(
    parameter int M_MAX = 10
);
    logic             i_start;
    logic [1:0]       i_code;
    logic [1:0]       i_op;
    logic [M_MAX-1:0] i_a;
    logic [M_MAX-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic             o_err;
    logic [M_MAX-1:0] o_result;

    modport master (
        output i_start, i_code, i_op, i_a, i_b,
        input  o_busy, o_done, o_err, o_result
    );

    modport slave (
        input  i_start, i_code, i_op, i_a, i_b,
        output o_busy, o_done, o_err, o_result
    );
endinterface

// File: rtl/gf_arith_unit.sv
// GF(2^m) multiply / square / Fermat inverse for m = 6, 8, 10.
// Built on a digit-serial shift-and-add core that consumes DIGIT bits of b per cycle.
module gf_arith_unit #(
    parameter int M_MAX = 10,
    parameter int DIGIT = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    gf_arith_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_INV_SQ, S_INV_MUL, S_DONE} state_t;

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_INV = 2'd2;
    localparam logic [1:0] OP_BAD = 2'd3;
    localparam logic [1:0] CODE_BAD = 2'd3;

    function automatic logic [3:0] code_m(input logic [1:0] code);
        case (code)
            2'd0:    return 4'd6;
            2'd1:    return 4'd8;
            2'd2:    return 4'd10;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [M_MAX:0] code_poly(input logic [1:0] code);
        case (code)
            2'd0:    return (M_MAX+1)'(11'h043);
            2'd1:    return (M_MAX+1)'(11'h11D);
            2'd2:    return (M_MAX+1)'(11'h409);
            default: return {(M_MAX+1){1'b0}};
        endcase
    endfunction

    function automatic logic [M_MAX-1:0] field_mask(input logic [3:0] m);
        logic [M_MAX-1:0] r;
        for (int i = 0; i < M_MAX; i++) begin
            r[i] = (i < int'(m));
        end
        return r;
    endfunction

    // Multiply by x; bit m can only be set after the shift, so one conditional XOR reduces it.
    function automatic logic [M_MAX-1:0] xtime(input logic [M_MAX-1:0] v, input logic [3:0] m,
                                                input logic [M_MAX:0] poly);
        logic [M_MAX:0] t;
        t = {v, 1'b0};
        t = t[m] ? (t ^ poly) : t;
        return t[M_MAX-1:0];
    endfunction

    state_t           state_q;
    logic [3:0]       m_q;
    logic [M_MAX:0]   poly_q;
    logic [3:0]       cnt_q;
    logic [3:0]       round_q;
    logic [M_MAX-1:0] sq_q;
    logic [M_MAX-1:0] inv_acc_q;
    logic [M_MAX-1:0] core_acc_q, core_sh_q, core_b_q;
    logic [M_MAX-1:0] core_acc_d, core_sh_d, core_b_d;
    logic             o_busy_q, o_done_q, o_err_q;
    logic [M_MAX-1:0] o_result_q;

    logic [3:0]       cap_m_s;
    logic [M_MAX-1:0] cap_mask_s, a_m_s, b_m_s;
    logic [3:0]       l_last_s;
    logic             last_s;
    logic             req_err_s;

    assign cap_m_s    = code_m(bus.i_code);
    assign cap_mask_s = field_mask(cap_m_s);
    assign a_m_s      = bus.i_a & cap_mask_s;
    assign b_m_s      = bus.i_b & cap_mask_s;
    assign req_err_s  = (bus.i_code == CODE_BAD) || (bus.i_op == OP_BAD) ||
                        ((bus.i_op == OP_INV) && (a_m_s == {M_MAX{1'b0}}));
    assign l_last_s   = 4'((int'(m_q) + DIGIT - 1) / DIGIT - 1);
    assign last_s     = (cnt_q == l_last_s);

    // One core step: DIGIT shift-and-add iterations over the low bits of b.
    always_comb begin
        core_acc_d = core_acc_q;
        core_sh_d  = core_sh_q;
        core_b_d   = core_b_q;
        for (int j = 0; j < DIGIT; j++) begin
            core_acc_d = core_acc_d ^ (core_b_d[0] ? core_sh_d : {M_MAX{1'b0}});
            core_sh_d  = xtime(core_sh_d, m_q, poly_q);
            core_b_d   = core_b_d >> 1;
        end
    end

    // Control FSM, operand sequencing and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            m_q        <= 4'd0;
            poly_q     <= {(M_MAX+1){1'b0}};
            cnt_q      <= 4'd0;
            round_q    <= 4'd0;
            sq_q       <= {M_MAX{1'b0}};
            inv_acc_q  <= {M_MAX{1'b0}};
            core_acc_q <= {M_MAX{1'b0}};
            core_sh_q  <= {M_MAX{1'b0}};
            core_b_q   <= {M_MAX{1'b0}};
            o_busy_q   <= 1'b0;
            o_done_q   <= 1'b0;
            o_err_q    <= 1'b0;
            o_result_q <= {M_MAX{1'b0}};
        end else begin
            o_done_q <= (state_q == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (bus.i_start) begin
                        o_result_q <= {M_MAX{1'b0}};
                        o_busy_q   <= 1'b1;
                        m_q        <= cap_m_s;
                        poly_q     <= code_poly(bus.i_code);
                        cnt_q      <= 4'd0;
                        round_q    <= 4'd1;
                        sq_q       <= a_m_s;
                        inv_acc_q  <= {{(M_MAX-1){1'b0}}, 1'b1};
                        core_acc_q <= {M_MAX{1'b0}};
                        core_sh_q  <= a_m_s;
                        core_b_q   <= (bus.i_op == OP_MUL) ? b_m_s : a_m_s;
                        o_err_q    <= req_err_s;
                        if (req_err_s) begin
                            state_q <= S_DONE;
                        end else if (bus.i_op == OP_INV) begin
                            state_q <= S_INV_SQ;
                        end else begin
                            state_q <= S_MUL;
                        end
                    end else begin
                        o_busy_q <= 1'b0;
                    end
                end
                S_MUL: begin
                    core_acc_q <= core_acc_d;
                    core_sh_q  <= core_sh_d;
                    core_b_q   <= core_b_d;
                    cnt_q      <= cnt_q + 4'd1;
                    if (last_s) begin
                        o_result_q <= core_acc_d;
                        state_q    <= S_DONE;
                    end else begin
                        state_q <= S_MUL;
                    end
                end
                S_INV_SQ: begin
                    core_acc_q <= core_acc_d;
                    core_sh_q  <= core_sh_d;
                    core_b_q   <= core_b_d;
                    cnt_q      <= cnt_q + 4'd1;
                    if (last_s) begin
                        sq_q       <= core_acc_d;
                        core_acc_q <= {M_MAX{1'b0}};
                        core_sh_q  <= inv_acc_q;
                        core_b_q   <= core_acc_d;
                        cnt_q      <= 4'd0;
                        state_q    <= S_INV_MUL;
                    end else begin
                        state_q <= S_INV_SQ;
                    end
                end
                S_INV_MUL: begin
                    core_acc_q <= core_acc_d;
                    core_sh_q  <= core_sh_d;
                    core_b_q   <= core_b_d;
                    cnt_q      <= cnt_q + 4'd1;
                    if (last_s) begin
                        inv_acc_q <= core_acc_d;
                        if (round_q == m_q - 4'd1) begin
                            o_result_q <= core_acc_d;
                            state_q    <= S_DONE;
                        end else begin
                            round_q    <= round_q + 4'd1;
                            core_acc_q <= {M_MAX{1'b0}};
                            core_sh_q  <= sq_q;
                            core_b_q   <= sq_q;
                            cnt_q      <= 4'd0;
                            state_q    <= S_INV_SQ;
                        end
                    end else begin
                        state_q <= S_INV_MUL;
                    end
                end
                S_DONE: begin
                    o_busy_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    o_busy_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy   = o_busy_q;
    assign bus.o_done   = o_done_q;
    assign bus.o_err    = o_err_q;
    assign bus.o_result = o_result_q;
endmodule

// File: tb/tb_gf_arith_unit.sv
// Bench for gf_arith_unit: DIGIT=1 and DIGIT=2 instances driven in lockstep and
// checked against a polynomial-arithmetic model with brute-force inverse.
module tb_gf_arith_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gf_arith_if #(.M_MAX(10)) if0 ();
    gf_arith_if #(.M_MAX(10)) if1 ();

    gf_arith_unit #(.M_MAX(10), .DIGIT(1)) u_d1 (.i_clk(clk), .i_rst(rst), .bus(if0));
    gf_arith_unit #(.M_MAX(10), .DIGIT(2)) u_d2 (.i_clk(clk), .i_rst(rst), .bus(if1));

    logic       done_w [2];
    logic       busy_w [2];
    logic       err_w  [2];
    logic [9:0] res_w  [2];
    assign done_w[0] = if0.o_done;  assign done_w[1] = if1.o_done;
    assign busy_w[0] = if0.o_busy;  assign busy_w[1] = if1.o_busy;
    assign err_w[0]  = if0.o_err;   assign err_w[1]  = if1.o_err;
    assign res_w[0]  = if0.o_result; assign res_w[1] = if1.o_result;

    logic       pend [2];
    logic       got  [2];
    int         exp_lat [2];
    int         acc_cyc;
    logic [9:0] exp_res;
    logic       exp_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int fm(input int code);
        return (code == 0) ? 6 : (code == 1) ? 8 : (code == 2) ? 10 : 0;
    endfunction

    function automatic logic [10:0] fpoly(input int code);
        return (code == 0) ? 11'h043 : (code == 1) ? 11'h11D : 11'h409;
    endfunction

    // Full carry-less product, then long-division reduction from the top bit down.
    function automatic logic [9:0] fmul(input int code, input logic [9:0] a, input logic [9:0] b);
        int m;
        logic [19:0] p;
        logic [19:0] pw;
        m = fm(code);
        p = 20'd0;
        pw = 20'(fpoly(code));
        for (int i = 0; i < m; i++) if (b[i]) p = p ^ (20'(a & 10'((1 << m) - 1)) << i);
        for (int i = 2 * m - 2; i >= m; i--) if (p[i]) p = p ^ (pw << (i - m));
        return p[9:0];
    endfunction

    function automatic logic [9:0] finv(input int code, input logic [9:0] a);
        int m;
        m = fm(code);
        for (int x = 1; x < (1 << m); x++) if (fmul(code, a, 10'(x)) == 10'd1) return 10'(x);
        return 10'd0;
    endfunction

    task automatic drive(input int code, input int op, input logic [9:0] a, input logic [9:0] b);
        if0.i_code = 2'(code); if1.i_code = 2'(code);
        if0.i_op = 2'(op);     if1.i_op = 2'(op);
        if0.i_a = a;           if1.i_a = a;
        if0.i_b = b;           if1.i_b = b;
    endtask

    task automatic set_start(input logic s);
        if0.i_start = s; if1.i_start = s;
    endtask

    task automatic expect_op(input int code, input int op, input logic [9:0] a, input logic [9:0] b);
        int m;
        logic [9:0] am;
        m = fm(code);
        am = a & 10'((1 << m) - 1);
        exp_err = (code == 3) || (op == 3) || (op == 2 && am == 10'd0);
        if (exp_err) exp_res = 10'd0;
        else if (op == 0) exp_res = fmul(code, a, b);
        else if (op == 1) exp_res = fmul(code, a, a);
        else exp_res = finv(code, a);
        for (int d = 0; d < 2; d++) begin
            int len;
            len = (m + d) / (d + 1);
            exp_lat[d] = exp_err ? 1 : (op == 2) ? 2 * (m - 1) * len + 1 : len + 1;
            pend[d] = 1'b1;
            got[d] = 1'b0;
        end
        acc_cyc = cyc + 1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (got[0] && got[1]) break;
        end
        chk("done_seen", {30'd0, got[0], got[1]}, 32'd3);
        pend[0] = 1'b0; pend[1] = 1'b0;
    endtask

    task automatic run_op(input int code, input int op, input logic [9:0] a, input logic [9:0] b);
        @(posedge clk); #1;
        drive(code, op, a, b);
        set_start(1'b1);
        expect_op(code, op, a, b);
        @(posedge clk); #1;
        set_start(1'b0);
        wait_done();
    endtask

    task automatic check_idle(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_busy"}, 32'(busy_w[d]), 32'd0);
            chk({tag, "_done"}, 32'(done_w[d]), 32'd0);
            chk({tag, "_err"}, 32'(err_w[d]), 32'd0);
            chk({tag, "_result"}, 32'(res_w[d]), 32'd0);
        end
    endtask

    // Compare process: every o_done pulse is checked against the pending expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (done_w[d]) begin
                chk("done_expected", 32'(pend[d]), 32'd1);
                if (pend[d]) begin
                    chk("result", 32'(res_w[d]), 32'(exp_res));
                    chk("err", 32'(err_w[d]), 32'(exp_err));
                    chk("latency", 32'(cyc - acc_cyc), 32'(exp_lat[d]));
                    pend[d] = 1'b0;
                    got[d] = 1'b1;
                end
            end
        end
    end

    initial begin
        pend[0] = 1'b0; pend[1] = 1'b0; got[0] = 1'b0; got[1] = 1'b0;
        set_start(1'b0);
        drive(0, 0, 10'd0, 10'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset");

        // Hand-derived values pinning the model.
        chk("model_mul8", 32'(fmul(1, 10'h080, 10'h002)), 32'h01D);
        chk("model_mul10", 32'(fmul(2, 10'h200, 10'h002)), 32'h009);
        chk("model_sqr6", 32'(fmul(0, 10'h020, 10'h020)), 32'h030);
        chk("model_inv6", 32'(finv(0, 10'h002)), 32'h021);
        chk("model_inv10", 32'(finv(2, 10'h002)), 32'h204);

        run_op(1, 0, 10'h080, 10'h002);
        chk("mul8_lat_d1", 32'(exp_lat[0]), 32'd9);
        repeat (3) @(negedge clk);
        chk("result_held", 32'(res_w[0]), 32'h01D);
        run_op(2, 0, 10'h200, 10'h002);
        run_op(0, 1, 10'h020, 10'h000);
        run_op(0, 1, 10'h3E0, 10'h3FF);
        run_op(0, 2, 10'h002, 10'h000);
        chk("inv6_lat_d1", 32'(exp_lat[0]), 32'd61);
        run_op(2, 2, 10'h002, 10'h000);
        run_op(1, 2, 10'h300, 10'h000);
        run_op(3, 0, 10'h005, 10'h003);
        run_op(1, 3, 10'h005, 10'h003);

        // Error then MUL with start held high: second request lands in the idle cycle after done.
        @(posedge clk); #1;
        drive(0, 2, 10'h000, 10'h000);
        set_start(1'b1);
        expect_op(0, 2, 10'h000, 10'h000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (got[0] && got[1]) break;
        end
        chk("b2b_first_done", {30'd0, got[0], got[1]}, 32'd3);
        drive(1, 0, 10'h0A5, 10'h03C);
        expect_op(1, 0, 10'h0A5, 10'h03C);
        @(posedge clk); #1;
        set_start(1'b0);
        wait_done();

        // Start pulse during an inverse must not disturb it.
        @(posedge clk); #1;
        drive(1, 2, 10'h053, 10'h000);
        set_start(1'b1);
        expect_op(1, 2, 10'h053, 10'h000);
        @(posedge clk); #1;
        set_start(1'b0);
        repeat (10) @(posedge clk);
        #1 drive(2, 0, 10'h3FF, 10'h3FF);
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        wait_done();

        // Reset in the middle of a multiply: no done may follow.
        @(posedge clk); #1;
        drive(2, 0, 10'h1A7, 10'h2C3);
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("busy_mid_mul", 32'(busy_w[0]), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_idle("midrst");
        repeat (20) @(negedge clk);

        // Random products and inverses in every field.
        for (int code = 0; code < 3; code++) begin
            for (int k = 0; k < 6; k++) run_op(code, 0, 10'($urandom), 10'($urandom));
            run_op(code, 1, 10'($urandom), 10'd0);
            for (int k = 0; k < 2; k++) begin
                logic [9:0] a;
                a = 10'($urandom_range(1, (1 << fm(code)) - 1));
                run_op(code, 2, a, 10'd0);
                chk("a_x_inv_d1", 32'(fmul(code, a, res_w[0])), 32'd1);
                chk("a_x_inv_d2", 32'(fmul(code, a, res_w[1])), 32'd1);
            end
        end

        // Every nonzero element of GF(2^6).
        for (int a = 1; a < 64; a++) begin
            run_op(0, 2, 10'(a), 10'd0);
            chk("inv6_all_d1", 32'(fmul(0, 10'(a), res_w[0])), 32'd1);
            chk("inv6_all_d2", 32'(fmul(0, 10'(a), res_w[1])), 32'd1);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
